// File: rtl/hash_feat_fetch_pkg.sv
// Shared hash-encoding definitions: corner count, default table address width
// and the feature-fetch FSM state encoding.
package hash_feat_fetch_pkg;

    localparam int unsigned NUM_CORNER     = 8;
    localparam int unsigned IDX_W          = 3;
    localparam int unsigned CNT_W          = 4;
    localparam int unsigned ADDR_W_DEFAULT = 19;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StOut   = 2'd2
    } state_e;

endpackage

// File: rtl/hash_feat_fetch.sv
// Gathers the eight corner features of one hash-grid cube: accepts a set of
// corner hash indices plus a level base, issues eight in-order table reads and
// presents the returned words as one feature set in corner order.
module hash_feat_fetch
    import hash_feat_fetch_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
    parameter int unsigned FEAT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] in_idx [0:NUM_CORNER-1],
    input  logic [ADDR_W-1:0]    in_base,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_W-1:0]    mem_req_addr,
    input  logic                 mem_rsp_valid,
    input  logic [FEAT_W-1:0]    mem_rsp_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FEAT_W-1:0]    out_feat [0:NUM_CORNER-1]
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  issue_cnt_q, rsp_cnt_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] idx_q  [NUM_CORNER];
    logic [FEAT_W-1:0] feat_q [NUM_CORNER];
    logic              in_hs, req_hs, rsp_take, rsp_done, out_hs;
    logic              unused_idx_hi;

    assign in_hs    = in_valid & in_ready;
    assign req_hs   = mem_req_valid & mem_req_ready;
    assign out_hs   = out_valid & out_ready;
    // Responses only land while gathering and while slots remain; extras are dropped.
    assign rsp_take = (state_q == StFetch) & mem_rsp_valid & (rsp_cnt_q < CNT_W'(NUM_CORNER));
    // Leave FETCH in the cycle the last slot fills so OUT starts right after it.
    assign rsp_done = (rsp_cnt_q == CNT_W'(NUM_CORNER)) |
                      (rsp_take & (rsp_cnt_q == CNT_W'(NUM_CORNER - 1)));

    // Address wraps silently modulo the table size.
    assign mem_req_addr = base_q + idx_q[issue_cnt_q[IDX_W-1:0]];
    assign out_feat     = feat_q;

    // Index bits above the table address width never take part in addressing.
    always_comb begin
        unused_idx_hi = 1'b0;
        for (int unsigned k = 0; k < NUM_CORNER; k++) begin
            unused_idx_hi = unused_idx_hi ^ (^in_idx[k][DATA_SIZE-1:ADDR_W]);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; any stray encoding falls back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_hs)    state_d = StFetch;
            StFetch: if (rsp_done) state_d = StOut;
            StOut:   if (out_hs)   state_d = StIdle;
            default:               state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from the state; in_ready is held low during reset.
    always_comb begin
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        out_valid     = 1'b0;
        case (state_q)
            StIdle:  in_ready      = rstn;
            StFetch: mem_req_valid = (issue_cnt_q < CNT_W'(NUM_CORNER));
            StOut:   out_valid     = 1'b1;
            default: ;
        endcase
    end

    // Captured request set, issue/response counters and gathered features.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issue_cnt_q <= '0;
            rsp_cnt_q   <= '0;
            base_q      <= '0;
            for (int unsigned k = 0; k < NUM_CORNER; k++) begin
                idx_q[k]  <= '0;
                feat_q[k] <= '0;
            end
        end else if (in_hs) begin
            issue_cnt_q <= '0;
            rsp_cnt_q   <= '0;
            base_q      <= in_base;
            for (int unsigned k = 0; k < NUM_CORNER; k++) begin
                idx_q[k] <= in_idx[k][ADDR_W-1:0];
            end
        end else begin
            if (req_hs) begin
                issue_cnt_q <= issue_cnt_q + 1'b1;
            end
            if (rsp_take) begin
                feat_q[rsp_cnt_q[IDX_W-1:0]] <= mem_rsp_data;
                rsp_cnt_q                    <= rsp_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hash_feat_fetch.sv
// Randomized bench for hash_feat_fetch with an in-order memory model and a
// reference computed directly from the addressing rule.
module tb_hash_feat_fetch;
    import hash_feat_fetch_pkg::*;

    localparam int DW = 32;
    localparam int AW = 19;
    localparam int FW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_idx [0:7];
    logic [AW-1:0] in_base = '0;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rsp_valid;
    logic [FW-1:0] mem_rsp_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [FW-1:0] out_feat [0:7];

    hash_feat_fetch #(
        .DATA_SIZE (DW),
        .ADDR_W    (AW),
        .FEAT_W    (FW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_idx        (in_idx),
        .in_base       (in_base),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_feat      (out_feat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: in-order reads, data = addr + 100, latency 'lat' cycles.
    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } rd_t;

    rd_t           rdq[$];
    logic [AW-1:0] issued[$];
    int            lat = 2;
    bit            rand_ready = 1'b0;
    int            ncyc = 0;
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    initial begin
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (rdq.size() > 0 && rdq[0].due <= ncyc) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = FW'(rdq[0].addr) + 100;
                void'(rdq.pop_front());
            end else begin
                mem_rsp_valid = 1'b0;
            end
            mem_req_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (prev_stall && rstn) begin
                check("req_valid_held", mem_req_valid, 1);
                check("req_addr_held", mem_req_addr, prev_addr);
            end
            if (mem_req_valid && mem_req_ready) begin
                issued.push_back(mem_req_addr);
                rdq.push_back('{mem_req_addr, ncyc + lat});
            end
            prev_stall = mem_req_valid && !mem_req_ready;
            prev_addr  = mem_req_addr;
        end
    end

    logic [FW-1:0] last_feat [8];

    task automatic run_set(input logic [AW-1:0] base, input logic [DW-1:0] idx [8],
                           input int exp_lat, input int hold);
        logic [AW-1:0] exp_addr [8];
        logic [FW-1:0] exp_feat [8];
        int            n;
        bit            seen;
        bit            saw_ready;
        bit            ok;
        for (int k = 0; k < 8; k++) begin
            exp_addr[k] = AW'((longint'(base) + longint'(idx[k])) % (longint'(1) << AW));
            exp_feat[k] = FW'(exp_addr[k]) + 100;
        end
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", in_ready, 1);
        issued.delete();
        in_base = base;
        for (int k = 0; k < 8; k++) in_idx[k] = idx[k];
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        seen = 1'b0;
        saw_ready = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (in_ready) saw_ready = 1'b1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("out_valid_rise", seen, 1);
        check("in_ready_busy", saw_ready, 0);
        if (exp_lat > 0) check("latency", n, exp_lat);
        check("issue_count", issued.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < issued.size()) check($sformatf("addr%0d", k), issued[k], exp_addr[k]);
            check($sformatf("feat%0d", k), out_feat[k], exp_feat[k]);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            ok = out_valid && !in_ready;
            for (int k = 0; k < 8; k++) if (out_feat[k] !== exp_feat[k]) ok = 1'b0;
            check($sformatf("hold_stable%0d", h), ok, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("out_valid_clear", out_valid, 0);
        check("in_ready_after_out", in_ready, 1);
        for (int k = 0; k < 8; k++) last_feat[k] = exp_feat[k];
    endtask

    task automatic inject_strays(input int cnt);
        for (int i = 0; i < cnt; i++) rdq.push_back('{AW'($urandom), 0});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] idx_v [8];
        int            n;
        bit            bad;

        for (int k = 0; k < 8; k++) in_idx[k] = '0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_feat0", out_feat[0], 0);
        check("rst_out_feat7", out_feat[7], 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Directed: base 0, idx k*3, L=2, memory always ready.
        for (int k = 0; k < 8; k++) idx_v[k] = DW'(k * 3);
        lat = 2;
        rand_ready = 1'b0;
        run_set('0, idx_v, 11, 0);

        // Address wrap and upper index bits ignored.
        idx_v[0] = 32'h0000_0020;
        idx_v[1] = 32'hFFF8_0005;
        for (int k = 2; k < 8; k++) idx_v[k] = $urandom;
        run_set(19'h7FFF0, idx_v, 11, 0);
        check("wrap_addr0", issued[0], 19'h00010);
        check("wrap_addr1", issued[1], 19'h7FFF5);

        // Stalling memory and a consumer holding off for 5 cycles.
        for (int k = 0; k < 8; k++) idx_v[k] = $urandom;
        lat = 3;
        rand_ready = 1'b1;
        run_set(AW'($urandom), idx_v, 0, 5);

        // Stray responses while idle must not disturb the held features.
        inject_strays(3);
        repeat (6) @(negedge clk);
        check("idle_out_valid", out_valid, 0);
        bad = 1'b0;
        for (int k = 0; k < 8; k++) if (out_feat[k] !== last_feat[k]) bad = 1'b1;
        check("idle_stray_feat", bad, 0);

        // Reset after 3 requests, then stray responses after release.
        rand_ready = 1'b0;
        lat = 20;
        for (int k = 0; k < 8; k++) idx_v[k] = $urandom;
        @(negedge clk);
        in_base = AW'($urandom);
        for (int k = 0; k < 8; k++) in_idx[k] = idx_v[k];
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        issued.delete();
        n = 0;
        while (issued.size() < 3 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("pre_reset_reqs", issued.size(), 3);
        rstn = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_req_valid", mem_req_valid, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_feat3", out_feat[3], 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        rdq.delete();
        inject_strays(2);
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid || mem_req_valid) bad = 1'b1;
        end
        check("post_rst_quiet", bad, 0);
        bad = 1'b0;
        for (int k = 0; k < 8; k++) if (out_feat[k] !== '0) bad = 1'b1;
        check("post_rst_feat_zero", bad, 0);

        // Next set after the abandoned one completes normally.
        lat = 2;
        for (int k = 0; k < 8; k++) idx_v[k] = $urandom;
        run_set(AW'($urandom), idx_v, 11, 0);

        // Random sets: random stalls, latency and consumer hold-off.
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < 8; k++) idx_v[k] = $urandom;
            lat = int'($urandom_range(1, 4));
            rand_ready = ($urandom_range(0, 1) != 0);
            run_set(AW'($urandom), idx_v, rand_ready ? 0 : lat + 9, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
